// File: rtl/bank_write_ctrl.sv
// bank_write_ctrl: scatters a raster pixel stream into four 2x2-parity banks with registered writes.
module bank_write_ctrl #(
   parameter int RAM_AW = 17,
   parameter int QN = 8,
   parameter int IMG_W = 640,
   parameter int IMG_H = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [QN-1:0]     s_data,
   input  logic              s_valid,
   input  logic              s_sof,
   input  logic              s_eol,
   output logic              s_ready,
   input  logic              rsta_busy,
   output logic              ena1,
   output logic              ena2,
   output logic              ena3,
   output logic              ena4,
   output logic              wea1,
   output logic              wea2,
   output logic              wea3,
   output logic              wea4,
   output logic [RAM_AW-1:0] AA1,
   output logic [RAM_AW-1:0] AA2,
   output logic [RAM_AW-1:0] AA3,
   output logic [RAM_AW-1:0] AA4,
   output logic [QN-1:0]     DA1,
   output logic [QN-1:0]     DA2,
   output logic [QN-1:0]     DA3,
   output logic [QN-1:0]     DA4,
   output logic              frame_done,
   output logic              err
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [RAM_AW-1:0] HALF_W = RAM_AW'(IMG_W / 2);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic live;
   logic [CW-1:0] col, wcol;
   logic [RW-1:0] row, wrow;
   logic [RAM_AW-1:0] row_base, wbase, waddr;
   logic [3:0] en;
   logic [RAM_AW-1:0] aa [4];
   logic [QN-1:0] da [4];
   logic [1:0] wbank;
   logic acc, restart, wr, eol_col, last;
   assign s_ready = live & ~rsta_busy & (state != DONE);
   assign acc = s_valid & s_ready;
   assign restart = acc & s_sof;
   assign wr = restart | (acc & (state == RUN));
   // a sof beat is always written as pixel (0,0), wherever the counters were
   assign wcol = restart ? '0 : col;
   assign wrow = restart ? '0 : row;
   assign wbase = restart ? '0 : row_base;
   assign waddr = wbase + RAM_AW'(wcol[CW-1:1]);
   assign wbank = {wrow[0], wcol[0]};
   assign eol_col = wcol == CW'(IMG_W - 1);
   assign last = eol_col && (wrow == RW'(IMG_H - 1));
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         live <= 1'b0;
         col <= '0;
         row <= '0;
         row_base <= '0;
         en <= '0;
         frame_done <= 1'b0;
         err <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            aa[i] <= '0;
            da[i] <= '0;
         end
      end else begin
         live <= 1'b1;
         en <= wr ? 4'(1 << wbank) : 4'b0;
         frame_done <= wr && last;
         if (wr) begin
            aa[wbank] <= waddr;
            da[wbank] <= s_data;
         end
         if ((restart && state == RUN) || (wr && s_eol != eol_col))
            err <= 1'b1;
         if (state == DONE)
            state <= IDLE;
         else if (wr)
            state <= last ? DONE : RUN;
         // row_base advances by one bank row after every odd image row
         if (wr) begin
            col <= eol_col ? '0 : wcol + 1'b1;
            row <= last ? '0 : eol_col ? wrow + 1'b1 : wrow;
            row_base <= last ? '0 : (eol_col && wrow[0]) ? wbase + HALF_W : wbase;
         end
      end
   end
   assign {ena4, ena3, ena2, ena1} = en;
   assign {wea4, wea3, wea2, wea1} = en;
   assign AA1 = aa[0];
   assign AA2 = aa[1];
   assign AA3 = aa[2];
   assign AA4 = aa[3];
   assign DA1 = da[0];
   assign DA2 = da[1];
   assign DA3 = da[2];
   assign DA4 = da[3];
endmodule

// File: tb/tb_bank_write_ctrl.sv
// tb_bank_write_ctrl: randomized raster stimulus checked each cycle against a pixel-level bank model.
module tb_bank_write_ctrl;
   localparam int AW = 17;
   localparam int QN = 8;
   localparam int W = 16;
   localparam int H = 8;
   localparam int HW = W / 2;
   logic clk = 0, rst = 1, s_valid = 0, s_sof = 0, s_eol = 0, rsta_busy = 0;
   logic [QN-1:0] s_data = '0;
   logic s_ready, frame_done, err;
   logic ena1, ena2, ena3, ena4, wea1, wea2, wea3, wea4;
   logic [AW-1:0] AA1, AA2, AA3, AA4;
   logic [QN-1:0] DA1, DA2, DA3, DA4;
   logic [3:0] ena, wea;
   logic [AW-1:0] aa [4];
   logic [QN-1:0] da [4];
   assign ena = {ena4, ena3, ena2, ena1};
   assign wea = {wea4, wea3, wea2, wea1};
   assign aa[0] = AA1;
   assign aa[1] = AA2;
   assign aa[2] = AA3;
   assign aa[3] = AA4;
   assign da[0] = DA1;
   assign da[1] = DA2;
   assign da[2] = DA3;
   assign da[3] = DA4;
   always #5 clk = ~clk;
   bank_write_ctrl #(.RAM_AW(AW), .QN(QN), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_eol(s_eol),
      .s_ready(s_ready), .rsta_busy(rsta_busy),
      .ena1(ena1), .ena2(ena2), .ena3(ena3), .ena4(ena4),
      .wea1(wea1), .wea2(wea2), .wea3(wea3), .wea4(wea4),
      .AA1(AA1), .AA2(AA2), .AA3(AA3), .AA4(AA4),
      .DA1(DA1), .DA2(DA2), .DA3(DA3), .DA4(DA4),
      .frame_done(frame_done), .err(err)
   );
   int n_vec = 0, n_bad = 0;
   bit m_live = 0, m_in = 0, m_err = 0, m_fd = 0, acc = 0;
   int mcol = 0, mrow = 0, gcol = 0, grow = 0, fd_cnt = 0;
   logic [3:0] m_en = '0;
   logic [AW-1:0] m_aa [4];
   logic [QN-1:0] m_da [4];
   logic [QN-1:0] obs [4][64];
   int wcnt [4][64];
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic clear_obs();
      fd_cnt = 0;
      for (int b = 0; b < 4; b++)
         for (int a = 0; a < 64; a++) begin
            obs[b][a] = '0;
            wcnt[b][a] = 0;
         end
   endtask
   // one clock: apply inputs, advance the model by the pixel rules, then compare after the edge
   task automatic cycle(input bit r, input bit b, input bit v, input bit sf, input bit el, input logic [QN-1:0] d);
      int bk;
      rst = r; rsta_busy = b; s_valid = v; s_sof = sf; s_eol = el; s_data = d;
      acc = v && m_live && !b && !m_fd;
      if (r) begin
         m_live = 0; m_in = 0; m_err = 0; m_fd = 0; m_en = '0; mcol = 0; mrow = 0;
         for (int i = 0; i < 4; i++) begin
            m_aa[i] = '0;
            m_da[i] = '0;
         end
      end else begin
         m_live = 1; m_fd = 0; m_en = '0;
         if (acc && sf) begin
            if (m_in) m_err = 1;
            m_in = 1; mcol = 0; mrow = 0;
         end
         if (acc && m_in) begin
            bk = (mrow % 2) * 2 + mcol % 2;
            m_en = 4'(1 << bk);
            m_aa[bk] = AW'((mrow / 2) * HW + mcol / 2);
            m_da[bk] = d;
            if (el != (mcol == W - 1)) m_err = 1;
            if (mcol == W - 1 && mrow == H - 1) begin
               m_fd = 1; m_in = 0;
            end else if (mcol == W - 1) begin
               mcol = 0; mrow++;
            end else mcol++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      chk("s_ready", s_ready, m_live && !rsta_busy && !m_fd);
      chk("ena", ena, m_en);
      chk("wea", wea, m_en);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("AA%0d", i + 1), aa[i], m_aa[i]);
         chk($sformatf("DA%0d", i + 1), da[i], m_da[i]);
         if (ena[i] === 1'b1) begin
            obs[i][aa[i][5:0]] = da[i];
            wcnt[i][aa[i][5:0]]++;
         end
      end
      chk("frame_done", frame_done, m_fd);
      chk("err", err, m_err);
      if (frame_done === 1'b1) fd_cnt++;
   endtask
   task automatic idle(input int n);
      repeat (n) cycle(0, 0, 0, 0, 0, '0);
   endtask
   function automatic logic [QN-1:0] pix(input int c, input int r);
      return (c == 0 && r == 0) ? 8'h11 : (c == 1 && r == 0) ? 8'h22 : (c == 0 && r == 1) ? 8'h33 :
             (c == 1 && r == 1) ? 8'h44 : (c == 5 && r == 7) ? 8'h57 : 8'($urandom);
   endfunction
   task automatic beat(input int gap, input int busy, input int flip, input int sofp);
      bit v, b, sf, el;
      if ($urandom_range(99) < sofp) begin
         gcol = 0; grow = 0;
      end
      v = $urandom_range(99) >= gap;
      b = $urandom_range(99) < busy;
      sf = gcol == 0 && grow == 0;
      el = gcol == W - 1;
      if ($urandom_range(99) < flip) el = !el;
      cycle(0, b, v, sf, el, pix(gcol, grow));
      if (acc) begin
         if (gcol == W - 1) begin
            gcol = 0; grow = (grow == H - 1) ? 0 : grow + 1;
         end else gcol++;
      end
   endtask
   task automatic run_frame(input int gap, input int busy);
      int k = 0;
      do begin
         beat(gap, busy, 0, 0);
         k++;
      end while (!(acc && gcol == 0 && grow == 0) && k < 3000);
      chk("frame_end_in_budget", k < 3000, 1);
   endtask
   task automatic run_to(input int c, input int r);
      int k = 0;
      while (!(gcol == c && grow == r) && k < 3000) begin
         beat(10, 0, 0, 0);
         k++;
      end
      chk("position_in_budget", k < 3000, 1);
   endtask
   initial begin
      int bad, c0;
      for (int i = 0; i < 4; i++) begin
         m_aa[i] = '0;
         m_da[i] = '0;
      end
      repeat (3) cycle(1, 0, 0, 0, 0, '0);
      chk("rst_ready_low", s_ready, 0);
      idle(1);
      chk("ready_rise", s_ready, 1);
      repeat (4) cycle(0, 0, 1, 0, 0, 8'hAA);
      chk("idle_drop_ena", ena, 0);
      clear_obs();
      run_frame(0, 0);
      idle(2);
      chk("bank1_addr0", obs[0][0], 8'h11);
      chk("bank2_addr0", obs[1][0], 8'h22);
      chk("bank3_addr0", obs[2][0], 8'h33);
      chk("bank4_addr0", obs[3][0], 8'h44);
      chk("bank4_addr26", obs[3][26], 8'h57);
      chk("clean_fd_pulses", fd_cnt, 1);
      chk("clean_err", err, 0);
      for (int b = 0; b < 4; b++) begin
         bad = 0;
         for (int a = 0; a < 64; a++)
            if (wcnt[b][a] != (a < 32 ? 1 : 0)) bad++;
         chk($sformatf("bank%0d_write_once", b + 1), bad, 0);
      end
      repeat (37) beat(0, 0, 0, 0);
      c0 = gcol;
      repeat (10) begin
         beat(0, 100, 0, 0);
         chk("busy_no_write", ena, 0);
         chk("busy_not_ready", s_ready, 0);
      end
      chk("busy_col_held", gcol, c0);
      fd_cnt = 0;
      run_frame(20, 10);
      idle(2);
      chk("busy_frame_fd", fd_cnt, 1);
      run_to(10, 3);
      gcol = 0; grow = 0;
      beat(0, 0, 0, 0);
      chk("sof_mid_err", err, 1);
      chk("sof_mid_ena", ena, 4'b0001);
      chk("sof_mid_AA1", AA1, 0);
      fd_cnt = 0;
      run_frame(10, 10);
      idle(2);
      chk("sof_mid_fd", fd_cnt, 1);
      chk("sof_mid_err_sticky", err, 1);
      run_to(0, 5);
      cycle(1, 0, 1, 0, 0, 8'h5A);
      cycle(1, 0, 1, 0, 0, 8'h5A);
      chk("rst_err", err, 0);
      chk("rst_ena", ena, 0);
      chk("rst_AA4", AA4, 0);
      chk("rst_fd", frame_done, 0);
      fd_cnt = 0;
      run_frame(0, 0);
      chk("aborted_no_fd", fd_cnt, 0);
      run_frame(15, 5);
      idle(2);
      chk("after_rst_fd", fd_cnt, 1);
      chk("after_rst_err", err, 0);
      beat(0, 0, 100, 0);
      chk("eol_err", err, 1);
      repeat (8) begin
         repeat (300) beat(25, 15, 2, 1);
         if ($urandom_range(1) == 1) cycle(1, 0, 1, 0, 0, 8'h00);
      end
      idle(3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
